// File: rtl/axi4_w_sender_buf_if.sv
`default_nettype none
// ============================================================================
// Module  : axi4_w_sender_buf_if
// Brief   : AXI4 W-channel signal bundle with master and slave views.
// Rev     : 1.0 - initial release
// ============================================================================
interface axi4_w_sender_buf_if #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic [USER_WIDTH-1:0]   wuser;
    logic                    wvalid;
    logic                    wready;

    modport master (output wdata, wstrb, wlast, wuser, wvalid, input wready);
    modport slave  (input wdata, wstrb, wlast, wuser, wvalid, output wready);
endinterface
`default_nettype wire

// File: rtl/axi4_w_sender_buf.sv
`default_nettype none
// ============================================================================
// Module  : axi4_w_sender_buf
// Brief   : Buffered W-channel sender; drains bursts in AW decision order,
//           forwarding or dropping each. Optional cut-through: AXI4_W_SENDER_BYPASS_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module axi4_w_sender_buf #(
    parameter int AXI_DATA_WIDTH     = 64,
    parameter int AXI_USER_WIDTH     = 6,
    parameter int W_BUFFER_DEPTH     = 16,
    parameter int LOG_W_BUFFER_DEPTH = 4,
    parameter int TRANS_DEPTH        = 8,
    parameter int LOG_TRANS_DEPTH    = 3
) (
    input  logic                axi4_aclk,
    input  logic                axi4_arstn,
    input  logic                dec_valid,
    input  logic                dec_drop,
    output logic                dec_ready,
    output logic                stall_aw,
    output logic                drop_done,
    output logic                wlast_received,
    input  logic                response_sent,
    axi4_w_sender_buf_if.slave  s_axi4_w,
    axi4_w_sender_buf_if.master m_axi4_w
);
    localparam int c_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int c_BEAT_WIDTH = 1 + AXI_USER_WIDTH + c_STRB_WIDTH + AXI_DATA_WIDTH;
    localparam logic [LOG_W_BUFFER_DEPTH:0]   c_W_FULL       = (LOG_W_BUFFER_DEPTH+1)'(W_BUFFER_DEPTH);
    localparam logic [LOG_W_BUFFER_DEPTH-1:0] c_W_LAST_IDX   = LOG_W_BUFFER_DEPTH'(W_BUFFER_DEPTH-1);
    localparam logic [LOG_TRANS_DEPTH:0]      c_DEC_FULL     = (LOG_TRANS_DEPTH+1)'(TRANS_DEPTH);
    localparam logic [LOG_TRANS_DEPTH-1:0]    c_DEC_LAST_IDX = LOG_TRANS_DEPTH'(TRANS_DEPTH-1);
    localparam logic [LOG_TRANS_DEPTH:0]      c_WL_MAX       = {(LOG_TRANS_DEPTH+1){1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                      r_state;
    logic                        r_dec_mem [TRANS_DEPTH];
    logic [LOG_TRANS_DEPTH-1:0]  r_dec_wptr, r_dec_rptr;
    logic [LOG_TRANS_DEPTH:0]    r_dec_cnt;
    logic [c_BEAT_WIDTH-1:0]     r_w_mem [W_BUFFER_DEPTH];
    logic [LOG_W_BUFFER_DEPTH-1:0] r_w_wptr, r_w_rptr;
    logic [LOG_W_BUFFER_DEPTH:0] r_w_cnt;
    logic [LOG_TRANS_DEPTH:0]    r_wlast_cnt;

    logic                        w_dec_ready, w_dec_push, w_dec_pop;
    logic                        w_w_full, w_w_empty, w_w_push, w_w_pop, w_w_bypass;
    logic                        w_s_ready, w_s_hs, w_burst_end, w_drop_done;
    logic                        w_wl_inc, w_wl_dec;
    logic [c_BEAT_WIDTH-1:0]     w_s_beat, w_head;
    logic [AXI_DATA_WIDTH-1:0]   w_head_data;
    logic [c_STRB_WIDTH-1:0]     w_head_strb;
    logic [AXI_USER_WIDTH-1:0]   w_head_user;
    logic                        w_head_last;

    assign w_dec_ready    = (r_dec_cnt != c_DEC_FULL);
    assign dec_ready      = w_dec_ready;
    assign stall_aw       = ~w_dec_ready;
    assign w_dec_push     = dec_valid & w_dec_ready;
    assign w_dec_pop      = (r_state == ST_IDLE) && (r_dec_cnt != '0);

    assign w_w_full       = (r_w_cnt == c_W_FULL);
    assign w_w_empty      = (r_w_cnt == '0);
    assign w_s_beat       = {s_axi4_w.wlast, s_axi4_w.wuser, s_axi4_w.wstrb, s_axi4_w.wdata};
    assign w_head         = r_w_mem[r_w_rptr];
    assign w_head_data    = w_head[AXI_DATA_WIDTH-1:0];
    assign w_head_strb    = w_head[AXI_DATA_WIDTH +: c_STRB_WIDTH];
    assign w_head_user    = w_head[AXI_DATA_WIDTH+c_STRB_WIDTH +: AXI_USER_WIDTH];
    assign w_head_last    = w_head[c_BEAT_WIDTH-1];

    // Master outputs stay zero unless a beat is actually being presented.
    always_comb begin
        m_axi4_w.wdata  = '0;
        m_axi4_w.wstrb  = '0;
        m_axi4_w.wlast  = 1'b0;
        m_axi4_w.wuser  = '0;
        m_axi4_w.wvalid = 1'b0;
        w_s_ready       = ~w_w_full;
        w_w_bypass      = 1'b0;
        w_w_pop         = 1'b0;
        w_burst_end     = 1'b0;
        w_drop_done     = 1'b0;
        case (r_state)
            ST_FWD: begin
                if (!w_w_empty) begin
                    m_axi4_w.wdata  = w_head_data;
                    m_axi4_w.wstrb  = w_head_strb;
                    m_axi4_w.wlast  = w_head_last;
                    m_axi4_w.wuser  = w_head_user;
                    m_axi4_w.wvalid = 1'b1;
                    w_w_pop         = m_axi4_w.wready;
                    w_burst_end     = m_axi4_w.wready & w_head_last;
                end
`ifdef AXI4_W_SENDER_BYPASS_EN
                else begin
                    // Cut-through only while nothing older is buffered, so order holds.
                    w_w_bypass      = 1'b1;
                    m_axi4_w.wdata  = s_axi4_w.wdata;
                    m_axi4_w.wstrb  = s_axi4_w.wstrb;
                    m_axi4_w.wlast  = s_axi4_w.wlast;
                    m_axi4_w.wuser  = s_axi4_w.wuser;
                    m_axi4_w.wvalid = s_axi4_w.wvalid;
                    w_s_ready       = m_axi4_w.wready;
                    w_burst_end     = s_axi4_w.wvalid & m_axi4_w.wready & s_axi4_w.wlast;
                end
`endif
            end
            ST_DROP: begin
                if (!w_w_empty) begin
                    w_w_pop     = 1'b1;
                    w_burst_end = w_head_last;
                    w_drop_done = w_head_last;
                end
            end
            default: ;
        endcase
    end

    assign s_axi4_w.wready = w_s_ready;
    assign drop_done       = w_drop_done;
    assign w_s_hs          = s_axi4_w.wvalid & w_s_ready;
    assign w_w_push        = w_s_hs & ~w_w_bypass;

    always_ff @(posedge axi4_aclk) begin
        if (w_w_push)   r_w_mem[r_w_wptr]     <= w_s_beat;
        if (w_dec_push) r_dec_mem[r_dec_wptr] <= dec_drop;
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_dec_wptr <= '0;
            r_dec_rptr <= '0;
            r_dec_cnt  <= '0;
            r_w_wptr   <= '0;
            r_w_rptr   <= '0;
            r_w_cnt    <= '0;
        end else begin
            if (w_dec_push) r_dec_wptr <= (r_dec_wptr == c_DEC_LAST_IDX) ? '0 : r_dec_wptr + 1'b1;
            if (w_dec_pop)  r_dec_rptr <= (r_dec_rptr == c_DEC_LAST_IDX) ? '0 : r_dec_rptr + 1'b1;
            if (w_dec_push && !w_dec_pop)      r_dec_cnt <= r_dec_cnt + 1'b1;
            else if (w_dec_pop && !w_dec_push) r_dec_cnt <= r_dec_cnt - 1'b1;

            if (w_w_push) r_w_wptr <= (r_w_wptr == c_W_LAST_IDX) ? '0 : r_w_wptr + 1'b1;
            if (w_w_pop)  r_w_rptr <= (r_w_rptr == c_W_LAST_IDX) ? '0 : r_w_rptr + 1'b1;
            if (w_w_push && !w_w_pop)      r_w_cnt <= r_w_cnt + 1'b1;
            else if (w_w_pop && !w_w_push) r_w_cnt <= r_w_cnt - 1'b1;
        end
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_dec_pop) r_state <= r_dec_mem[r_dec_rptr] ? ST_DROP : ST_FWD;
                ST_FWD,
                ST_DROP: if (w_burst_end) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Completed-burst count for the B sender; a response with nothing pending is ignored.
    assign w_wl_inc = w_s_hs & s_axi4_w.wlast;
    assign w_wl_dec = response_sent & (r_wlast_cnt != '0);

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_wlast_cnt <= '0;
        end else if (w_wl_inc && !w_wl_dec) begin
            if (r_wlast_cnt != c_WL_MAX) r_wlast_cnt <= r_wlast_cnt + 1'b1;
        end else if (w_wl_dec && !w_wl_inc) begin
            r_wlast_cnt <= r_wlast_cnt - 1'b1;
        end
    end

    assign wlast_received = (r_wlast_cnt != '0);
endmodule
`default_nettype wire
